// File: rtl/fft_bitrev_buf_pkg.sv
// -----------------------------------------------------------------------------
// fft_bitrev_buf_pkg
//
// Shared definitions for the 16-point FFT output reorder stage.
//   FFT_LOG2N / FFT_N : transform size (log2 and point count)
//   CALC_TEMP_W       : width of one signed real or imaginary sample
//   calc_temp_t       : one signed sample of CALC_TEMP_W bits
//   calc_cplx_t       : packed {re, im} pair as it travels on the data bus
//   bitrev()          : reverses the bits of an FFT_LOG2N-bit index
// -----------------------------------------------------------------------------
package fft_bitrev_buf_pkg;

    localparam int FFT_LOG2N   = 4;
    localparam int FFT_N       = 1 << FFT_LOG2N;
    localparam int CALC_TEMP_W = 16;

    typedef logic signed [CALC_TEMP_W-1:0] calc_temp_t;

    typedef struct packed {
        calc_temp_t re;
        calc_temp_t im;
    } calc_cplx_t;

    // Bit 0 of the index becomes the MSB of the result, and so on.
    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
        logic [FFT_LOG2N-1:0] r;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            r[b] = idx[FFT_LOG2N-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_buf_if.sv
// -----------------------------------------------------------------------------
// fft_bitrev_buf_if
//
// Stream bundle around the reorder buffer: one valid/ready channel going in
// (bit-reversed order) and one coming out (natural order).
//   in_valid  / in_ready       upstream handshake
//   in_re     / in_im          signed sample, bit-reversed arrival order
//   out_valid / out_ready      downstream handshake
//   out_re    / out_im         signed sample, natural order
//   out_idx                    natural frequency index of out_re/out_im
//   out_last                   high together with out_idx == N-1
// Modports:
//   slave  : the reorder buffer itself
//   master : whatever sits around it (upstream source + downstream sink)
// -----------------------------------------------------------------------------
interface fft_bitrev_buf_if
    import fft_bitrev_buf_pkg::*;
#(
    parameter int DATA_W = CALC_TEMP_W,
    parameter int LOG2N  = FFT_LOG2N
);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic [LOG2N-1:0]         out_idx;
    logic                     out_last;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

endinterface

// File: rtl/fft_bitrev_bank.sv
// -----------------------------------------------------------------------------
// fft_bitrev_bank
//
// Simple dual-port RAM holding both ping-pong banks: the bank select is the
// MSB of each address. One write port, one synchronous read port whose output
// register doubles as the reorder stage's output data register, so it only
// updates on rd_en and is cleared by reset. Array contents are not reset.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (read register only)
//   wr_en, wr_addr, wr_data : write port
//   rd_en, rd_addr          : read request, data appears in rd_data next edge
//   rd_data                 : registered read data, held while rd_en is low
// -----------------------------------------------------------------------------
module fft_bitrev_bank
    import fft_bitrev_buf_pkg::*;
#(
    parameter int DATA_W = CALC_TEMP_W,
    parameter int AW     = FFT_LOG2N + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [2*DATA_W-1:0]   rd_data
);

    logic [2*DATA_W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register: holds its value while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_buf.sv
// -----------------------------------------------------------------------------
// fft_bitrev_buf
//
// Output reorder stage of the 16-point FFT. Samples arrive in bit-reversed
// order and leave in natural order (index 0..N-1). Two banks are used as a
// ping-pong pair so the next frame can be written while the previous one
// drains. Each bank has a full flag: the writer fills the bank it owns until
// the flag is set, the reader drains a full bank and clears the flag after
// loading its last entry.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset; drops partial and full frames
//   bus    : fft_bitrev_buf_if.slave (valid/ready in, valid/ready out,
//            out_idx natural index, out_last with index N-1)
//
// Build option:
//   BITREV_SCALE_EN : when defined, each output part is divided by N with
//                     round-half-up; timing and handshake are unchanged.
// -----------------------------------------------------------------------------
module fft_bitrev_buf
    import fft_bitrev_buf_pkg::*;
#(
    parameter int DATA_W = CALC_TEMP_W,
    parameter int LOG2N  = FFT_LOG2N
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_bitrev_buf_if.slave bus
);

    localparam logic [LOG2N-1:0] IDX_LAST = '1;

    // Control state
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       bank_full;
    logic [1:0]       bank_full_nxt;

    logic             wr_fire;
    logic             wr_wrap;
    logic             refill;
    logic             rd_wrap;
    logic [LOG2N-1:0] wr_row;

    // Output stage
    logic                     out_valid_p1;
    logic [LOG2N-1:0]         out_idx_p1;
    logic                     out_last_p1;
    logic [2*DATA_W-1:0]      rd_word_p1;
    logic signed [DATA_W-1:0] rd_re_p1;
    logic signed [DATA_W-1:0] rd_im_p1;

`ifdef BITREV_SCALE_EN
    // Divide by N with round-half-up. The extra bit keeps x + N/2 from
    // wrapping at the positive end of the range.
    function automatic logic signed [DATA_W-1:0] scale_round(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W:0] ext;
        logic signed [DATA_W:0] sum;
        logic signed [DATA_W:0] shf;
        ext = {x[DATA_W-1], x};
        sum = ext + $signed((DATA_W+1)'(1 << (LOG2N-1)));
        shf = sum >>> LOG2N;
        return shf[DATA_W-1:0];
    endfunction
`endif

    // ---- stage 0: write side and read request ----
    assign wr_row        = bitrev(wr_cnt);
    assign bus.in_ready  = !bank_full[wr_bank];
    assign wr_fire       = bus.in_valid && !bank_full[wr_bank];
    assign wr_wrap       = wr_fire && (wr_cnt == IDX_LAST);

    // The output register can take a new sample when it is empty or its
    // current sample leaves this cycle, and the reader's bank holds a frame.
    assign refill        = (!out_valid_p1 || bus.out_ready) && bank_full[rd_bank];
    assign rd_wrap       = refill && (rd_cnt == IDX_LAST);

    // The writer only ever owns a non-full bank and the reader only a full
    // one, so a set and a clear in the same cycle always hit different banks.
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_wrap) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (rd_wrap) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    fft_bitrev_bank #(
        .DATA_W (DATA_W),
        .AW     (LOG2N + 1)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_fire),
        .wr_addr ({wr_bank, wr_row}),
        .wr_data ({bus.in_re, bus.in_im}),
        .rd_en   (refill),
        .rd_addr ({rd_bank, rd_cnt}),
        .rd_data (rd_word_p1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            bank_full    <= 2'b00;
            out_valid_p1 <= 1'b0;
            out_idx_p1   <= '0;
            out_last_p1  <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;

            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_wrap) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (refill) begin
                out_valid_p1 <= 1'b1;
                out_idx_p1   <= rd_cnt;
                out_last_p1  <= (rd_cnt == IDX_LAST);
                rd_cnt       <= rd_cnt + 1'b1;
                if (rd_wrap) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (out_valid_p1 && bus.out_ready) begin
                out_valid_p1 <= 1'b0;
            end
        end
    end

    // ---- stage 1: registered output ----
    assign rd_re_p1 = rd_word_p1[2*DATA_W-1:DATA_W];
    assign rd_im_p1 = rd_word_p1[DATA_W-1:0];

`ifdef BITREV_SCALE_EN
    assign bus.out_re = scale_round(rd_re_p1);
    assign bus.out_im = scale_round(rd_im_p1);
`else
    assign bus.out_re = rd_re_p1;
    assign bus.out_im = rd_im_p1;
`endif

    assign bus.out_valid = out_valid_p1;
    assign bus.out_idx   = out_idx_p1;
    assign bus.out_last  = out_last_p1;

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_buf
//
// Randomized bench for the FFT bit-reverse reorder buffer. The reference model
// collects each frame in arrival order and, once 16 samples are in, predicts
// the natural-order output as out[n] = in[bitrev(n)] (optionally divided by 16
// with round-half-up when BITREV_SCALE_EN is defined).
// -----------------------------------------------------------------------------
module tb_fft_bitrev_buf;

    localparam int N  = 16;
    localparam int DW = 16;

    typedef struct {
        bit in_fire;
        bit out_fire;
        bit in_ready;
        bit out_valid;
        bit out_ready;
        bit out_last;
        int re;
        int im;
        int idx;
    } snap_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fft_bitrev_buf_if #(.DATA_W(DW), .LOG2N(4)) bus ();

    fft_bitrev_buf #(.DATA_W(DW), .LOG2N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    int stim_re[$];
    int stim_im[$];
    int got_re[$];
    int got_im[$];
    int got_idx[$];

    // Index with its 4 bits mirrored.
    function automatic int rev4(input int k);
        return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
    endfunction

    // Expected output value for a sample value x.
    function automatic int model_scale(input int x);
`ifdef BITREV_SCALE_EN
        int v;
        v = x + 8;
        if (v >= 0) return v / 16;
        return -((-v + 15) / 16);
`else
        return x;
`endif
    endfunction

    function automatic int rand_sample();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Observe everything just before the coming rising edge, then move to
    // 1 time unit after that edge so the caller can drive the next inputs.
    task automatic tick(output snap_t s);
        @(negedge clk);
        s.in_ready  = (bus.in_ready === 1'b1);
        s.out_valid = (bus.out_valid === 1'b1);
        s.out_ready = (bus.out_ready === 1'b1);
        s.in_fire   = (bus.in_valid === 1'b1) && s.in_ready;
        s.out_fire  = s.out_valid && s.out_ready;
        s.out_last  = (bus.out_last === 1'b1);
        s.re        = bus.out_re;
        s.im        = bus.out_im;
        s.idx       = bus.out_idx;
        @(posedge clk);
        #1;
    endtask

    // Push the samples in stim_re/stim_im through the DUT and score every
    // output against the frame model. out_ready is forced low for the first
    // `hold` cycles.
    task automatic stream(input int vld_pct, input int rdy_pct, input int hold,
                          output int in_stalls, output int out_gaps,
                          output int acc16_tick, output int first_vld_tick,
                          output snap_t at_hold, output int acc_at_hold);
        int    total;
        int    sent;
        int    got;
        int    cyc;
        int    fr_re[N];
        int    fr_im[N];
        int    exp_re[$];
        int    exp_im[$];
        int    exp_idx[$];
        bit    vld;
        bit    prev_stall;
        snap_t s;
        snap_t prev;

        total = stim_re.size();
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0;
        in_stalls = 0; out_gaps = 0; acc16_tick = -1; first_vld_tick = -1;
        acc_at_hold = 0;
        at_hold = '{default: 0};
        prev = '{default: 0};
        got_re.delete(); got_im.delete(); got_idx.delete();

        while (got < total && cyc < 4000) begin
            vld = (sent < total) && ($urandom_range(99) < vld_pct);
            bus.in_valid  = vld;
            bus.in_re     = (sent < total) ? DW'(stim_re[sent]) : '0;
            bus.in_im     = (sent < total) ? DW'(stim_im[sent]) : '0;
            bus.out_ready = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
            tick(s);

            if (s.in_fire) begin
                fr_re[sent % N] = stim_re[sent];
                fr_im[sent % N] = stim_im[sent];
                sent++;
                if (sent % N == 0) begin
                    for (int n = 0; n < N; n++) begin
                        exp_re.push_back(model_scale(fr_re[rev4(n)]));
                        exp_im.push_back(model_scale(fr_im[rev4(n)]));
                        exp_idx.push_back(n);
                    end
                    if (acc16_tick < 0) acc16_tick = cyc;
                end
            end
            if (vld && !s.in_ready) in_stalls++;
            if (hold > 0 && cyc == hold - 1) begin
                at_hold = s;
                acc_at_hold = sent;
            end

            if (prev_stall) begin
                checks++;
                if (!s.out_valid || s.re != prev.re || s.im != prev.im ||
                    s.idx != prev.idx || s.out_last != prev.out_last) begin
                    failures++;
                    $display("FAIL hold_stable cyc=%0d got valid=%0b idx=%0d re=%0d im=%0d last=%0b required valid=1 idx=%0d re=%0d im=%0d last=%0b",
                             cyc, s.out_valid, s.idx, s.re, s.im, s.out_last,
                             prev.idx, prev.re, prev.im, prev.out_last);
                end
            end

            if (s.out_valid && first_vld_tick < 0) first_vld_tick = cyc;
            if (got > 0 && !s.out_valid) out_gaps++;

            if (s.out_fire) begin
                checks++;
                if (exp_re.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected cyc=%0d got idx=%0d re=%0d required no output", cyc, s.idx, s.re);
                end else begin
                    int er, ei, en;
                    er = exp_re.pop_front();
                    ei = exp_im.pop_front();
                    en = exp_idx.pop_front();
                    if (s.re != er || s.im != ei || s.idx != en || s.out_last != (en == N - 1)) begin
                        failures++;
                        $display("FAIL out_data cyc=%0d got idx=%0d re=%0d im=%0d last=%0b required idx=%0d re=%0d im=%0d last=%0b",
                                 cyc, s.idx, s.re, s.im, s.out_last, en, er, ei, (en == N - 1));
                    end
                    got_re.push_back(s.re);
                    got_im.push_back(s.im);
                    got_idx.push_back(s.idx);
                    got++;
                end
            end

            prev_stall = s.out_valid && !s.out_ready;
            prev = s;
            cyc++;
        end

        checks++;
        if (got < total) begin
            failures++;
            $display("FAIL stream_timeout got %0d outputs required %0d", got, total);
        end

        // Everything offered has come out; nothing further may appear.
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick(s);
        checks++;
        if (s.out_valid) begin
            failures++;
            $display("FAIL drained_empty got out_valid=1 idx=%0d required out_valid=0", s.idx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_re = '0;
        bus.in_im = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got valid=%0b last=%0b required 0 0", bus.out_valid, bus.out_last);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %0b required 1", bus.in_ready);
        end
        checks++;
        if (bus.out_re !== '0 || bus.out_im !== '0 || bus.out_idx !== '0) begin
            failures++;
            $display("FAIL reset_data got re=%0d im=%0d idx=%0d required 0 0 0", bus.out_re, bus.out_im, bus.out_idx);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int    stalls, gaps, a16, fv, aah;
        snap_t ah;
        stim_re.delete(); stim_im.delete();
        for (int k = 0; k < N; k++) begin
            stim_re.push_back(100 + k);
            stim_im.push_back(-k);
        end
        stream(100, 100, 0, stalls, gaps, a16, fv, ah, aah);
        // Accept at edge E, register loads at E+1, seen before edge E+2.
        checks++;
        if (fv - a16 != 2) begin
            failures++;
            $display("FAIL single_latency got %0d ticks required 2", fv - a16);
        end
        checks++;
        if (got_re.size() != N) begin
            failures++;
            $display("FAIL single_count got %0d required %0d", got_re.size(), N);
        end else begin
            checks++;
            if (got_re[1] != model_scale(108) || got_re[3] != model_scale(112) || got_re[15] != model_scale(115)) begin
                failures++;
                $display("FAIL single_values got n1=%0d n3=%0d n15=%0d required %0d %0d %0d",
                         got_re[1], got_re[3], got_re[15], model_scale(108), model_scale(112), model_scale(115));
            end
        end
    endtask

    task automatic test_back_to_back();
        int    stalls, gaps, a16, fv, aah;
        snap_t ah;
        stim_re.delete(); stim_im.delete();
        for (int k = 0; k < 3 * N; k++) begin
            stim_re.push_back(rand_sample());
            stim_im.push_back(rand_sample());
        end
        stream(100, 100, 0, stalls, gaps, a16, fv, ah, aah);
        checks++;
        if (stalls != 0) begin
            failures++;
            $display("FAIL b2b_in_ready got %0d stalled cycles required 0", stalls);
        end
        checks++;
        if (gaps != 0) begin
            failures++;
            $display("FAIL b2b_out_gaps got %0d idle cycles required 0", gaps);
        end
    endtask

    task automatic test_stall();
        int    stalls, gaps, a16, fv, aah;
        snap_t ah;
        stim_re.delete(); stim_im.delete();
        for (int k = 0; k < 3 * N; k++) begin
            stim_re.push_back(rand_sample());
            stim_im.push_back(rand_sample());
        end
        stream(100, 100, 60, stalls, gaps, a16, fv, ah, aah);
        checks++;
        if (aah != 2 * N || ah.in_ready) begin
            failures++;
            $display("FAIL stall_accepts got %0d in_ready=%0b required %0d in_ready=0", aah, ah.in_ready, 2 * N);
        end
        checks++;
        if (!ah.out_valid || ah.idx != 0 || ah.re != model_scale(stim_re[0]) || ah.im != model_scale(stim_im[0])) begin
            failures++;
            $display("FAIL stall_head got valid=%0b idx=%0d re=%0d im=%0d required valid=1 idx=0 re=%0d im=%0d",
                     ah.out_valid, ah.idx, ah.re, ah.im, model_scale(stim_re[0]), model_scale(stim_im[0]));
        end
    endtask

    task automatic test_random();
        int    stalls, gaps, a16, fv, aah;
        snap_t ah;
        stim_re.delete(); stim_im.delete();
        for (int k = 0; k < 5 * N; k++) begin
            stim_re.push_back(rand_sample());
            stim_im.push_back(rand_sample());
        end
        stream(75, 50, 0, stalls, gaps, a16, fv, ah, aah);
    endtask

    task automatic test_mid_reset();
        int    stalls, gaps, a16, fv, aah, acc, cyc;
        snap_t ah;
        snap_t s;
        // One full frame plus 7 samples of the next, with the output blocked.
        acc = 0; cyc = 0;
        bus.out_ready = 1'b0;
        while (acc < N + 7 && cyc < 200) begin
            bus.in_valid = 1'b1;
            bus.in_re = DW'(rand_sample());
            bus.in_im = DW'(rand_sample());
            tick(s);
            if (s.in_fire) acc++;
            cyc++;
        end
        checks++;
        if (acc != N + 7) begin
            failures++;
            $display("FAIL mid_reset_fill got %0d accepts required %0d", acc, N + 7);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick(s);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick(s);
        checks++;
        if (s.out_valid || !s.in_ready || s.idx != 0) begin
            failures++;
            $display("FAIL mid_reset_state got out_valid=%0b in_ready=%0b idx=%0d required 0 1 0", s.out_valid, s.in_ready, s.idx);
        end
        stim_re.delete(); stim_im.delete();
        for (int k = 0; k < N; k++) begin
            stim_re.push_back(rand_sample());
            stim_im.push_back(rand_sample());
        end
        stream(100, 100, 0, stalls, gaps, a16, fv, ah, aah);
    endtask

`ifdef BITREV_SCALE_EN
    task automatic test_scale();
        int    stalls, gaps, a16, fv, aah;
        snap_t ah;
        stim_re.delete(); stim_im.delete();
        for (int k = 0; k < N; k++) begin
            stim_re.push_back(0);
            stim_im.push_back(0);
        end
        stim_re[0] = 32767;
        stim_im[0] = -32768;
        stim_re[1] = 7;
        stim_re[2] = -9;
        stream(100, 100, 0, stalls, gaps, a16, fv, ah, aah);
        checks++;
        if (got_re.size() != N) begin
            failures++;
            $display("FAIL scale_count got %0d required %0d", got_re.size(), N);
        end else begin
            checks++;
            // arrival 1 lands at index 8, arrival 2 at index 4
            if (got_re[0] != 2048 || got_im[0] != -2048 || got_re[8] != 0 || got_re[4] != -1) begin
                failures++;
                $display("FAIL scale_values got %0d %0d %0d %0d required 2048 -2048 0 -1",
                         got_re[0], got_im[0], got_re[8], got_re[4]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_random();
        test_mid_reset();
`ifdef BITREV_SCALE_EN
        test_scale();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_bitrev_buf.md
Name: fft_bitrev_buf

Overview:
- Output reorder stage of the 16-point 1-D FFT. It sits directly downstream of the final butterfly/delay stage.
- Takes complex results that arrive in bit-reversed order and emits them in natural order (index 0..15).
- Ping-pong double buffer, so a new frame can be written while the previous frame drains.
- Valid/ready handshake on both sides.

Parameters:
- DATA_W, 16, width of each signed real/imag sample (matches the codebase CalcTemp width).
- LOG2N, 4, log2 of FFT length. N = 1<<LOG2N = 16. Only 4 is verified.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  buffer can accept a sample.
- in_re  in  DATA_W  signed real part, bit-reversed order.
- in_im  in  DATA_W  signed imag part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_re  out  DATA_W  signed real part, natural order.
- out_im  out  DATA_W  signed imag part.
- out_idx  out  LOG2N  natural frequency index of the current output.
- out_last  out  1  high with idx N-1.

Behaviour:
- Reset is synchronous, active-low, single clock. With rst_n=0 at a clk edge:
  - wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, bank_full=2'b00.
  - out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0.
  - Memory contents are don't-care.
  - A reset mid-frame discards partial and full frames.
- Storage: two banks x N entries x {re,im}.
- Write side:
  - in_ready = !bank_full[wr_bank].
  - On in_valid&&in_ready, write mem[wr_bank][bitrev(wr_cnt)] and increment wr_cnt.
  - When wr_cnt wraps N-1 -> 0: set bank_full[wr_bank] and toggle wr_bank.
- Read side:
  - Output register is refilled when (!out_valid || out_ready) && bank_full[rd_bank].
  - Refill loads mem[rd_bank][rd_cnt] into out_re/out_im, out_idx=rd_cnt, out_last=(rd_cnt==N-1), out_valid=1, then increments rd_cnt.
  - After loading rd_cnt==N-1: clear bank_full[rd_bank] and toggle rd_bank.
  - If out_valid && out_ready and no refill is possible, out_valid <= 0.
  - Output data holds stable while out_valid && !out_ready.
- Latency: the first natural-order sample is valid on the clock edge after the edge that accepted the 16th input. One cycle of registered read.
- Throughput: 1 sample/clk sustained when out_ready=1 continuously.
- Simultaneous events:
  - A bank set-full (write side) and the other bank's clear (read side) in the same cycle are both applied.
  - The write side never targets the bank being read: the full flag protects it.
- Both banks full: in_ready=0 until the read side clears one.
- in_valid while in_ready=0: sample ignored, no state change.

Optional Feature:
- Macro BITREV_SCALE_EN.
- Defined: each output part = (x + 2^(LOG2N-1)) >>> LOG2N, i.e. divide by N with round-half-up.
  - Computed in DATA_W+1 bits so no overflow.
  - Result sign-extended back to DATA_W.
- Undefined: data passes unscaled. Timing and handshake are identical in both builds.

Decomposition:
- Shared header/package: FFT_N, FFT_LOG2N, the CalcTemp data width/bus macro, and the bitrev function for a LOG2N-bit index.
- One natural sub-module: fft_bitrev_bank, a single-write-port, synchronous-read N x 2*DATA_W RAM. Instantiated twice, or once with a bank-select address bit.

Test Plan:
- Single frame, out_ready=1: arrival k carries re=100+k, im=-k.
  - Required: out_idx n gives re=100+bitrev(n), e.g. n=1 -> 108, n=3 -> 112, n=15 -> 115.
  - out_last only at n=15. First out_valid exactly 1 cycle after the 16th accept.
- Back-to-back 3 frames, in_valid=1, out_ready=1: in_ready never drops. Outputs are continuous (48 cycles) and frames are correctly ordered.
- out_ready=0 throughout while 3 frames are offered:
  - in_ready falls after 32 accepts.
  - out_valid=1 with idx 0 held stable.
  - Releasing out_ready drains in order.
- Random out_ready toggling (50%): every sample emitted exactly once, in order. Data stable while stalled.
- rst_n=0 for 1 cycle after 7 inputs: out_valid=0 and in_ready=1 next cycle. A following full frame is output correctly with no stale data.
- BITREV_SCALE_EN build: inputs re=32767, im=-32768, re=7, re=-9.
  - Required outputs: 2048, -2048, 0, -1.
